imem_loader: RTL and testbench

- Byte-stream program loader that writes the four byte-lane instruction memories.
- Accepts a valid/ready byte stream carrying a 4-byte little-endian word-count header followed by the instruction payload.
- Emits one byte write per cycle to the lane-addressed memory write ports.
- Sits between the host-link receiver and the instruction memory bank; the core is held in reset until load_done.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory byte-stream loader:
// FSM state encoding, header/lane constants and the lane-enable decode.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHECK,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned NUM_LANES = 4;

  // One-hot write enable for the byte lane selected by the low address bits.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] lane);
    logic [NUM_LANES-1:0] oh;
    oh       = '0;
    oh[lane] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: takes a 4-byte little-endian word count
// followed by the payload and writes it, one byte per cycle, to the four
// byte-lane instruction memories.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte covering header and payload.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [3:0]  imem_we,
  output logic [31:0] imem_wr_addr,
  output logic [7:0]  imem_wr_data,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err
);

  state_e      state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [31:0] wcount_q, wcount_d;
  logic [31:0] bcnt_q, bcnt_d;
  logic        in_ready_q, in_ready_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept;
  logic        last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign accept    = in_valid && in_ready_q;
  assign last_byte = (bcnt_q == ({wcount_q[29:0], 2'b00} - 32'd1));

  // Next-state, header capture, payload write generation and status flags.
  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    wcount_d  = wcount_q;
    bcnt_d    = bcnt_q;
    we_d      = '0;
    addr_d    = addr_q;
    data_d    = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d   = ST_HDR;
          hdr_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      ST_HDR: begin
        if (accept) begin
          // Shift in from the top so the first byte lands in [7:0].
          wcount_d  = {in_data, wcount_q[31:8]};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ in_data;
`endif
          if (hdr_cnt_q == 2'(HDR_BYTES - 1)) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        bcnt_d = '0;
        if (wcount_q == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end else if (wcount_q > MEM_WORDS) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          we_d   = lane_onehot(bcnt_q[1:0]);
          addr_d = BASE_ADDR + {bcnt_q[31:2], 2'b00};
          data_d = in_data;
          bcnt_d = bcnt_q + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
          if (last_byte) state_d = ST_CSUM;
`else
          if (last_byte) state_d = ST_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          state_d = ((csum_q ^ in_data) == 8'h00) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    in_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
`else
    in_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA);
`endif
    busy_d = (state_d == ST_HDR) || (state_d == ST_CHECK) ||
             (state_d == ST_DATA) || (state_d == ST_CSUM);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hdr_cnt_q  <= '0;
      wcount_q   <= '0;
      bcnt_q     <= '0;
      in_ready_q <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      wcount_q   <= wcount_d;
      bcnt_q     <= bcnt_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over header and payload bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  assign in_ready     = in_ready_q;
  assign imem_we      = we_q;
  assign imem_wr_addr = addr_q;
  assign imem_wr_data = data_q;
  assign load_busy    = busy_q;
  assign load_done    = done_q;
  assign load_err     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a reference model derives each
// expected memory write from the byte index and pushes it to a scoreboard
// queue; a monitor pops and compares every write the DUT presents.
module tb_imem_loader;

  localparam int unsigned MEMW = 512;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [3:0]  imem_we;
  logic [31:0] imem_wr_addr;
  logic [7:0]  imem_wr_data;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  imem_loader #(
    .MEM_WORDS(MEMW),
    .BASE_ADDR(BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .imem_we     (imem_we),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [7:0]  data;
    int unsigned cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] empty[$];
  logic [7:0] pay[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every write the DUT presents must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && imem_we !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got we=%b addr=%h data=%h, expected no write",
                 imem_we, imem_wr_addr, imem_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_we", {28'd0, imem_we}, {28'd0, e.we});
        chk("wr_addr", imem_wr_addr, e.addr);
        chk("wr_data", {24'd0, imem_wr_data}, {24'd0, e.data});
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns the cycle number in which
  // the resulting write (if any) must appear.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap,
                           input bit with_start, output int unsigned acc);
    int unsigned t;
    t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", t);
    end
    acc = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic do_load(input logic [31:0] n, input logic [7:0] p[$],
                         input int unsigned gmin, input int unsigned gmax,
                         input bit mid_start, input bit bad_csum);
    logic [7:0]  hdr[4];
    logic [7:0]  x;
    int unsigned acc;
    hdr = '{n[7:0], n[15:8], n[23:16], n[31:24]};
    pulse_start();
    chk("start_busy", {31'd0, load_busy}, 32'd1);
    chk("start_clears_done", {31'd0, load_done}, 32'd0);
    chk("start_clears_err", {31'd0, load_err}, 32'd0);
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      x ^= hdr[i];
      send_byte(hdr[i], $urandom_range(gmax, gmin), 1'b0, acc);
    end
    if (n > MEMW) begin
      @(negedge clk);
      chk("check_cycle_busy", {31'd0, load_busy}, 32'd1);
      chk("check_cycle_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("oversize_err", {31'd0, load_err}, 32'd1);
      chk("oversize_done", {31'd0, load_done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("err_ready", {31'd0, in_ready}, 32'd0);
      chk("err_busy", {31'd0, load_busy}, 32'd0);
      return;
    end
    for (int unsigned k = 0; k < 4 * n; k++) begin
      x ^= p[k];
      send_byte(p[k], $urandom_range(gmax, gmin), mid_start && (k == 2), acc);
      exp_q.push_back('{we: 4'b0001 << (k % 4), addr: BASE + (k / 4) * 4,
                        data: p[k], cyc: acc});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h5A) : x, $urandom_range(gmax, gmin), 1'b0, acc);
    @(negedge clk);
    chk("csum_done", {31'd0, load_done}, {31'd0, !bad_csum});
    chk("csum_err", {31'd0, load_err}, {31'd0, bad_csum});
`else
    if (n == 0) begin
      @(negedge clk);
      chk("n0_check_cycle_done", {31'd0, load_done}, 32'd0);
    end
    @(negedge clk);
    chk("load_done", {31'd0, load_done}, 32'd1);
    chk("load_err_clear", {31'd0, load_err}, 32'd0);
`endif
    chk("end_busy", {31'd0, load_busy}, 32'd0);
    chk("end_ready", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic rand_payload(input int unsigned n);
    pay = {};
    for (int unsigned i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    int unsigned acc;
    logic [31:0] n;

    // Reset values.
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {28'd0, imem_we}, 32'd0);
    chk("rst_addr", imem_wr_addr, 32'd0);
    chk("rst_data", {24'd0, imem_wr_data}, 32'd0);
    chk("rst_busy", {31'd0, load_busy}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known two-word program.
    pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load(32'd2, pay, 0, 0, 1'b0, 1'b0);

    // Empty program, then oversize header, then a good load clearing the error.
    do_load(32'd0, empty, 0, 0, 1'b0, 1'b0);
    do_load(32'd513, empty, 0, 0, 1'b0, 1'b0);
    rand_payload(1);
    do_load(32'd1, pay, 0, 0, 1'b0, 1'b0);

    // Gapped stream with an ignored start pulse mid-payload.
    rand_payload(1);
    do_load(32'd1, pay, 2, 2, 1'b1, 1'b0);

    // Asynchronous reset after three payload bytes.
    pulse_start();
    send_byte(8'h01, 0, 1'b0, acc);
    repeat (3) send_byte(8'h00, 0, 1'b0, acc);
    for (int unsigned k = 0; k < 3; k++) begin
      send_byte(8'(8'hA0 + k), 0, 1'b0, acc);
      exp_q.push_back('{we: 4'b0001 << k, addr: BASE, data: 8'(8'hA0 + k), cyc: acc});
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_we", {28'd0, imem_we}, 32'd0);
    chk("arst_addr", imem_wr_addr, 32'd0);
    chk("arst_data", {24'd0, imem_wr_data}, 32'd0);
    chk("arst_busy", {31'd0, load_busy}, 32'd0);
    chk("arst_scoreboard", exp_q.size(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rand_payload(1);
    do_load(32'd1, pay, 0, 0, 1'b0, 1'b0);

    // Largest accepted program.
    rand_payload(MEMW);
    do_load(MEMW, pay, 0, 0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay = '{8'h13, 8'h00, 8'h00, 8'h00};
    do_load(32'd1, pay, 0, 0, 1'b0, 1'b0);
    do_load(32'd1, pay, 0, 0, 1'b0, 1'b1);
`endif

    // Randomized loads, including occasional oversize headers.
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(6, 0);
      if ($urandom_range(4, 0) == 0) n = MEMW + 1 + $urandom_range(100000, 0);
      if (n <= MEMW) rand_payload(n);
      else pay = {};
      do_load(n, pay, 0, $urandom_range(2, 0), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
